// File: rtl/demux_pkg.sv
// Shared types and constants for the demux arbiter: FSM states, requester count,
// address width and destination encodings.
package demux_pkg;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] DEST_A = 2'd0;
    localparam logic [ADDR_W-1:0] DEST_B = 2'd1;
    localparam logic [ADDR_W-1:0] DEST_C = 2'd2;
    localparam logic [ADDR_W-1:0] DEST_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One-hot pulse vector for a requester index.
    function automatic logic [N_REQ-1:0] onehot_req(input logic [ADDR_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_arbiter_if.sv
// Requester and demux-side signals of the arbiter. The master side is the
// request source and LED/demux consumer; the slave side is the arbiter.
interface demux_arbiter_if;
    import demux_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [ADDR_W*N_REQ-1:0] req_addr;
    logic [N_REQ-1:0]        req_data;
    logic [N_REQ-1:0]        req_done;
    logic [ADDR_W-1:0]       demux_addr;
    logic                    demux_data;
    logic                    busy;
    logic [N_REQ-1:0]        out_q;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_done, demux_addr, demux_data, busy, out_q
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_done, demux_addr, demux_data, busy, out_q
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: grants the first set request bit found
// searching upward from (last + 1) with wrap-around.
module rr_pick4
    import demux_pkg::*;
(
    input  logic [N_REQ-1:0]  req,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] gnt_idx,
    output logic              any
);

    // Walk from lowest to highest priority so the last hit is the winner;
    // the 2-bit index wraps naturally.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned and infers a latch.
        gnt_idx = last;
        any     = |req;
        for (int k = N_REQ; k >= 1; k--) begin
            logic [ADDR_W-1:0] idx;
            idx = last + ADDR_W'(k);
            if (req[idx]) gnt_idx = idx;
        end
    end

endmodule

// File: rtl/demux_arbiter.sv
// Round-robin arbiter that time-shares a 1-to-4 single-bit demux among four
// requesters and keeps a held copy of each destination's last routed bit.
module demux_arbiter
    import demux_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    demux_arbiter_if.slave  bus
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   grant_q, grant_d;
    logic [ADDR_W-1:0]   last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                data_q, data_d;
    logic [ADDR_W-1:0]   demux_addr_q, demux_addr_d;
    logic                demux_data_q, demux_data_d;
    logic                busy_q, busy_d;
    logic [N_REQ-1:0]    req_done_q, req_done_d;
    logic [N_REQ-1:0]    held_q, held_d;

    logic [ADDR_W-1:0]   pick_idx;
    logic                pick_any;
    logic [ADDR_W-1:0]   pick_addr;
    logic                pick_data;

    rr_pick4 u_pick (
        .req     (bus.req_valid),
        .last    (last_grant_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign pick_addr = bus.req_addr[{pick_idx, 1'b0} +: ADDR_W];
    assign pick_data = bus.req_data[pick_idx];

    // All outputs are registered and updated on the state transition that
    // enters the cycle they describe, so they never glitch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        demux_addr_d = demux_addr_q;
        demux_data_d = demux_data_q;
        busy_d       = busy_q;
        req_done_d   = '0;
        held_d       = held_q;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d      = pick_idx;
                    addr_d       = pick_addr;
                    data_d       = pick_data;
                    cnt_d        = CNT_W'(DWELL_CYCLES - 1);
                    demux_addr_d = pick_addr;
                    demux_data_d = pick_data;
                    busy_d       = 1'b1;
                    state_d      = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    demux_data_d = 1'b0;
                    req_done_d   = onehot_req(grant_q);
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                held_d[addr_q] = data_q;
                last_grant_d   = grant_q;
                busy_d         = 1'b0;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the held output bank is only four flops and must read as
            // zero after reset, so it is reset like any other state.
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= DEST_D;
            addr_q       <= '0;
            data_q       <= 1'b0;
            demux_addr_q <= '0;
            demux_data_q <= 1'b0;
            busy_q       <= 1'b0;
            req_done_q   <= '0;
            held_q       <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            demux_addr_q <= demux_addr_d;
            demux_data_q <= demux_data_d;
            busy_q       <= busy_d;
            req_done_q   <= req_done_d;
            held_q       <= held_d;
        end
    end

    assign bus.req_done   = req_done_q;
    assign bus.demux_addr = demux_addr_q;
    assign bus.demux_data = demux_data_q;
    assign bus.busy       = busy_q;
    assign bus.out_q      = held_q;

endmodule
